// File: rtl/audio_cfg_pkg.sv
// Shared types and constants for the audio codec configuration path.
// Holds arbiter FSM states, default bus widths and codec register addresses.
package audio_cfg_pkg;

    localparam int REG_W_DEF  = 7;
    localparam int DATA_W_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [6:0] REG_LHP_VOL      = 7'h02;
    localparam logic [6:0] REG_RHP_VOL      = 7'h03;
    localparam logic [6:0] REG_ANALOG_PATH  = 7'h04;
    localparam logic [6:0] REG_DIGITAL_PATH = 7'h05;
    localparam logic [6:0] REG_POWER        = 7'h06;
    localparam logic [6:0] REG_AUDIO_FMT    = 7'h07;
    localparam logic [6:0] REG_SAMPLE_RATE  = 7'h08;
    localparam logic [6:0] REG_ACTIVE       = 7'h09;

endpackage

// File: rtl/audio_cfg_arbiter_rr_pick.sv
// Round-robin pick: one-hot winner is the first set request at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; any_o is low when nothing is requesting.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    localparam int PW1 = PTR_W + 1;

    logic [PTR_W:0] pos;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + PW1'(k);
            if (pos >= PW1'(N)) begin
                pos = pos - PW1'(N);
            end
            if (!found && req_i[pos[PTR_W-1:0]]) begin
                found                 = 1'b1;
                gnt_o[pos[PTR_W-1:0]] = 1'b1;
                idx_o                 = pos[PTR_W-1:0];
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/audio_cfg_arbiter.sv
// Shares the codec manual-write port among N_REQ requesters, round-robin, one write in flight.
// Latency: grant 1 cycle after arbitration, send 1 cycle later, done 1 cycle after send_done.
// Backpressure: requests wait in ARB until the codec answers send_done or the write times out.
module audio_cfg_arbiter
    import audio_cfg_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int REG_W       = REG_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    rst,
    input  logic                    audio_init_done,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*REG_W-1:0]  req_reg,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic                    busy,
    output logic                    send,
    output logic [REG_W-1:0]        register,
    output logic [DATA_W-1:0]       data,
    input  logic                    send_done,
    output logic                    timeout_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    done_q;
    logic                err_q;
    logic                busy_q;
    logic                send_q;
    logic [REG_W-1:0]    reg_q;
    logic [DATA_W-1:0]   data_q;
    logic                terr_q;

    logic [N_REQ-1:0]    win_gnt;
    logic [PTR_W-1:0]    win_idx;
    logic                win_any;
    logic [REG_W-1:0]    sel_reg_d;
    logic [DATA_W-1:0]   sel_data_d;
    logic [PTR_W-1:0]    ptr_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                timeout_hit;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_comb begin
        sel_reg_d  = '0;
        sel_data_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) begin
                sel_reg_d  = req_reg[i*REG_W +: REG_W];
                sel_data_d = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next owner in line after the current one, wrapping at the last requester.
    assign ptr_d       = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            send_q <= 1'b0;
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (audio_init_done) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!audio_init_done) begin
                        state_q <= ST_IDLE;
                    end else if (win_any) begin
                        grant_q <= win_gnt;
                        owner_q <= win_idx;
                        reg_q   <= sel_reg_d;
                        data_q  <= sel_data_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    send_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion arriving on the last allowed cycle still counts as success.
                    if (send_done || timeout_hit) begin
                        done_q  <= grant_q;
                        err_q   <= !send_done;
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= ST_DONE;
                        if (!send_done) begin
                            terr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= audio_init_done ? ST_ARB : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign send        = send_q;
    assign register    = reg_q;
    assign data        = data_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_audio_cfg_arbiter.sv
// Bench for audio_cfg_arbiter: directed scenarios plus random traffic against a
// timestamp-based reference model of the arbitration and write handshake.
module tb_audio_cfg_arbiter;
    import audio_cfg_pkg::*;

    localparam int N  = 3;
    localparam int RW = 7;
    localparam int DW = 9;
    localparam int TO = 16;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            init_done = 1'b0;
    logic            send_done = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [N*RW-1:0] req_reg   = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            err;
    logic            busy;
    logic            send;
    logic            timeout_err;
    logic [RW-1:0]   register;
    logic [DW-1:0]   data;

    audio_cfg_arbiter #(
        .N_REQ       (N),
        .REG_W       (RW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLOCK_50        (clk),
        .rst             (rst_n),
        .audio_init_done (init_done),
        .req             (req),
        .req_reg         (req_reg),
        .req_data        (req_data),
        .grant           (grant),
        .done            (done),
        .err             (err),
        .busy            (busy),
        .send            (send),
        .register        (register),
        .data            (data),
        .send_done       (send_done),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode 0: waiting for init, 1: free to arbitrate, 2: write in flight, 3: completion cycle
    int            m_mode, m_ptr, m_owner, m_g, m_cyc;
    logic [N-1:0]  exp_grant, exp_done;
    logic          exp_err, exp_busy, exp_send, exp_terr;
    logic [RW-1:0] exp_reg;
    logic [DW-1:0] exp_data;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_owner = 0; m_g = 0;
        exp_grant = '0; exp_done = '0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_send = 1'b0; exp_terr = 1'b0; exp_reg = '0; exp_data = '0;
    endtask

    task automatic model_step();
        int el;
        m_cyc++;
        exp_send = 1'b0;
        exp_done = '0;
        exp_err  = 1'b0;
        case (m_mode)
            0: if (init_done) m_mode = 1;
            1: begin
                if (!init_done) begin
                    m_mode = 0;
                end else if (req != '0) begin
                    m_owner = pick(req, m_ptr);
                    m_g = m_cyc;
                    exp_grant = '0;
                    exp_grant[m_owner] = 1'b1;
                    exp_busy = 1'b1;
                    exp_reg  = req_reg[m_owner*RW +: RW];
                    exp_data = req_data[m_owner*DW +: DW];
                    m_mode = 2;
                end
            end
            2: begin
                el = m_cyc - m_g;
                if (el == 1) begin
                    exp_send = 1'b1;
                end else if (el >= 2 && (send_done || (el - 2 == TO - 1))) begin
                    exp_done = exp_grant;
                    exp_err  = !send_done;
                    if (!send_done) exp_terr = 1'b1;
                    exp_grant = '0;
                    m_ptr = (m_owner + 1) % N;
                    m_mode = 3;
                end
            end
            default: begin
                exp_busy = 1'b0;
                m_mode = init_done ? 1 : 0;
            end
        endcase
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- compare + monitor ----------------
    int          n_send = 0;
    int          n_done = 0;
    logic [15:0] send_log[$];

    initial begin
        forever begin
            @(negedge clk);
            check("grant", 32'(grant), 32'(exp_grant));
            check("done", 32'(done), 32'(exp_done));
            check("err", 32'(err), 32'(exp_err));
            check("busy", 32'(busy), 32'(exp_busy));
            check("send", 32'(send), 32'(exp_send));
            check("register", 32'(register), 32'(exp_reg));
            check("data", 32'(data), 32'(exp_data));
            check("timeout_err", 32'(timeout_err), 32'(exp_terr));
            if (send === 1'b1) begin
                n_send++;
                send_log.push_back({register, data});
            end
            if (done !== '0) n_done++;
        end
    end

    // ---------------- codec responder ----------------
    int codec_mode = 0;
    int codec_dly  = 2;
    int codec_hold = 5;
    bit codec_rand = 1'b0;
    int cd_wait    = -1;
    int cd_len     = 0;
    int cd_hold    = 1;

    initial begin
        int mode, dly, hold, r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cd_wait = -1; cd_len = 0; send_done = 1'b0;
            end else begin
                if (send === 1'b1) begin
                    mode = codec_mode; dly = codec_dly; hold = codec_hold;
                    if (codec_rand) begin
                        r = $urandom_range(0, 9);
                        mode = (r == 0) ? 1 : (r < 3) ? 2 : 0;
                        dly  = $urandom_range(0, 6);
                        hold = $urandom_range(2, 5);
                    end
                    cd_wait = (mode == 1) ? -1 : dly;
                    cd_hold = (mode == 2) ? hold : 1;
                end
                if (cd_wait == 0) begin
                    cd_len = cd_hold; cd_wait = -1;
                end else if (cd_wait > 0) begin
                    cd_wait--;
                end
                send_done = (cd_len > 0) || (codec_rand && $urandom_range(0, 39) == 0);
                if (cd_len > 0) cd_len--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input int limit, output int idx, output logic e);
        idx = -1;
        e = 1'bx;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done !== '0) begin
                for (int i = 0; i < N; i++) if (done[i]) idx = i;
                e = err;
                return;
            end
        end
        n_chk++; n_err++;
        $display("FAIL wait_done: no done within %0d cycles", limit);
    endtask

    task automatic wait_send(input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (send === 1'b1) return;
        end
        n_chk++; n_err++;
        $display("FAIL wait_send: no send within %0d cycles", limit);
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (grant === g) return;
        end
        n_chk++; n_err++;
        $display("FAIL wait_grant: grant %0h not seen within %0d cycles", g, limit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int            idx, k, s0, d0, base;
    logic          e;
    logic [15:0]   ent;
    logic [RW-1:0] t2_regs [3];

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // init gating, then first grant/send timing
        req_reg[0 +: RW]  = REG_POWER;
        req_data[0 +: DW] = 9'h0AA;
        req = 3'b001;
        repeat (100) @(negedge clk);
        check("t1_no_send", 32'(n_send), 32'd0);
        check("t1_no_grant", 32'(grant), 32'd0);
        init_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_send_early", 32'(send), 32'd0);
        @(negedge clk);
        check("t1_send", 32'(send), 32'd1);
        check("t1_reg", 32'(register), 32'h06);
        check("t1_data", 32'(data), 32'h0AA);
        wait_done(50, idx, e);
        check("t1_owner", 32'(idx), 32'd0);
        check("t1_err", 32'(e), 32'd0);
        req = '0;

        // three requesters served in order from a fresh pointer
        do_reset();
        t2_regs[0] = REG_LHP_VOL; t2_regs[1] = REG_RHP_VOL; t2_regs[2] = REG_DIGITAL_PATH;
        for (int i = 0; i < N; i++) begin
            req_reg[i*RW +: RW]  = t2_regs[i];
            req_data[i*DW +: DW] = DW'($urandom);
        end
        codec_dly = 10;
        base = send_log.size();
        req = 3'b111;
        for (int j = 0; j < N; j++) begin
            wait_done(100, idx, e);
            check("t2_order", 32'(idx), 32'(j));
            check("t2_err", 32'(e), 32'd0);
            if (idx >= 0) req[idx] = 1'b0;
        end
        check("t2_sends", 32'(send_log.size() - base), 32'd3);
        for (int j = 0; j < N; j++) begin
            if (send_log.size() > base + j) begin
                ent = send_log[base + j];
                check("t2_reg", 32'(ent[15:9]), 32'(t2_regs[j]));
            end
        end

        // fairness: req0 re-asserts at once while req2 waits
        req = 3'b001;
        wait_grant(3'b001, 20);
        req[2] = 1'b1;
        wait_done(100, idx, e);
        check("t3_first", 32'(idx), 32'd0);
        wait_done(100, idx, e);
        check("t3_fair", 32'(idx), 32'd2);
        req[2] = 1'b0;
        wait_done(100, idx, e);
        check("t3_again", 32'(idx), 32'd0);
        req = '0;

        // timeout, sticky flag, next request still served
        codec_mode = 1;
        req = 3'b010;
        wait_send(20);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done !== '0) begin k = c; break; end
        end
        check("t4_latency", 32'(k), 32'd16);
        check("t4_done", 32'(done), 32'h2);
        check("t4_err", 32'(err), 32'd1);
        check("t4_terr", 32'(timeout_err), 32'd1);
        req = '0;
        codec_mode = 0;
        codec_dly = 3;
        req = 3'b100;
        wait_done(60, idx, e);
        check("t4_next_owner", 32'(idx), 32'd2);
        check("t4_next_err", 32'(e), 32'd0);
        check("t4_sticky", 32'(timeout_err), 32'd1);
        req = '0;

        // send_done held for several cycles
        codec_mode = 2; codec_dly = 1; codec_hold = 5;
        s0 = n_send; d0 = n_done;
        req = 3'b001;
        wait_done(60, idx, e);
        req = '0;
        repeat (12) @(negedge clk);
        check("t5_one_send", 32'(n_send - s0), 32'd1);
        check("t5_one_done", 32'(n_done - d0), 32'd1);

        // asynchronous reset in the middle of a wait
        codec_mode = 1;
        req = 3'b010;
        wait_send(20);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_zero", 32'({grant, done, err, busy, send, timeout_err, register, data}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        codec_mode = 0; codec_dly = 2;
        wait_done(60, idx, e);
        check("t6_owner", 32'(idx), 32'd1);
        check("t6_err", 32'(e), 32'd0);
        check("t6_terr", 32'(timeout_err), 32'd0);
        req = '0;

        // random traffic checked against the model every cycle
        codec_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_reg[i*RW +: RW]  = RW'($urandom);
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req_reg[i*RW +: RW]  = RW'($urandom);
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (req[i] && $urandom_range(0, 99) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (init_done && $urandom_range(0, 299) == 0) init_done = 1'b0;
            else if (!init_done && $urandom_range(0, 7) == 0) init_done = 1'b1;
        end
        codec_rand = 1'b0;
        codec_mode = 0;
        req = '0;
        init_done = 1'b1;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
